instruction_decoder: RTL and testbench
======================================

INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all output registers.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 instruction  input  32  instruction word, sampled every rising clk edge.
REQ-005 alu_src  output  1  ALU operand-B select: 0 = register reg2, 1 = immediate imm.
REQ-006 alu_op  output  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-007 reg1  output  4  source register A index.
REQ-008 reg2  output  4  source register B index.
REQ-009 reg_dest  output  4  destination register index.
REQ-010 imm  output  16  zero-extended immediate field.
REQ-011 reg_write  output  1  1 = instruction writes reg_dest.
REQ-012 illegal  output  1  1 = opcode not recognised.

Function
REQ-013 Fields SHALL be: opcode = instruction[31:28], rd = [27:24], rn = [23:20], rm = [19:16], imm16 = [15:0].
REQ-014 Opcode table (alu_op, alu_src, reg_write) SHALL be: 0x0 NOP (00,0,0); 0x1 CMP (01,0,0); 0x2 ADD (00,0,1); 0x3 ADDI (00,1,1); 0x4 SUB (01,0,1); 0x5 SUBI (01,1,1); 0x6 AND (10,0,1); 0x7 ORR (11,0,1).
REQ-015 Opcodes 0x8-0xF SHALL set illegal=1 and drive all other outputs to NOP values.
REQ-016 NOP and illegal SHALL drive reg1, reg2, reg_dest, imm, alu_op, alu_src, reg_write to 0, regardless of the other fields.
REQ-017 Register-form ops (CMP, ADD, SUB, AND, ORR) SHALL drive reg1=rn, reg2=rm, imm=0.
REQ-018 Immediate-form ops (ADDI, SUBI) SHALL drive reg1=rn, reg2=0, imm=imm16.
REQ-019 CMP SHALL drive reg_dest=0; all other legal writing ops SHALL drive reg_dest=rd.
REQ-020 All outputs SHALL be registered: the decode of instruction present at rising edge N appears after edge N and holds until edge N+1 (1-cycle latency, no combinational input-to-output path).
REQ-021 A new instruction SHALL be accepted every cycle; there is no handshake or stall.
REQ-022 Any X-free instruction SHALL produce exactly one of: legal decode, NOP, or illegal=1.

Reset
REQ-023 While rst=1 all outputs SHALL be 0 (NOP decode, illegal=0), asynchronously and independent of clk.
REQ-024 On rst deassertion the first decode SHALL occur at the next rising clk edge; an instruction presented during reset SHALL NOT be decoded.
REQ-025 Reset asserted mid-stream SHALL immediately clear outputs; no previous decode persists.

Configuration
REQ-026 Macro DEC_IMM_EN defined: opcodes 0x3/0x5 decode as ADDI/SUBI per REQ-014/REQ-018.
REQ-027 Macro DEC_IMM_EN undefined: opcodes 0x3/0x5 SHALL be treated as illegal (REQ-015), alu_src SHALL be constantly 0 and imm constantly 0.

Verification
REQ-028 rst=1 then released, instruction=0x00000000, one clk -> all outputs 0, illegal=0.
REQ-029 instruction=0x21350001, one clk -> alu_op=00, alu_src=0, reg_dest=0001, reg1=0011, reg2=0101, imm=0, reg_write=1, illegal=0.
REQ-030 instruction=0x47410001, one clk -> alu_op=01, alu_src=0, reg_dest=0111, reg1=0100, reg2=0001, reg_write=1.
REQ-031 With DEC_IMM_EN: instruction=0x3A90BEEF -> alu_op=00, alu_src=1, reg_dest=1010, reg1=1001, reg2=0, imm=0xBEEF; without DEC_IMM_EN -> illegal=1, all else 0.
REQ-032 instruction=0x9FFFFFFF -> illegal=1, all other outputs 0; instruction=0x1123xxxx -> alu_op=01, reg_write=0, reg_dest=0, reg1=0010, reg2=0011.
REQ-033 Assert rst asynchronously between clk edges while ADD is decoded -> outputs 0 before next edge; input change between edges -> outputs unchanged until next edge.

Source files
------------

// File: rtl/instruction_decoder.sv
// instruction_decoder: registered 4-bit-opcode decoder for a small ALU ISA.
// Define DEC_IMM_EN to enable the ADDI/SUBI immediate forms (otherwise 0x3/0x5 are illegal).
module instruction_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic [3:0]  reg1,
    output logic [3:0]  reg2,
    output logic [3:0]  reg_dest,
    output logic [15:0] imm,
    output logic        reg_write,
    output logic        illegal
);
`ifdef DEC_IMM_EN
    localparam bit IMM_EN = 1'b1;
`else
    localparam bit IMM_EN = 1'b0;
`endif
    logic [3:0]  op;
    logic        is_imm_op, legal_reg, legal_imm;
    logic        alu_src_d, alu_src_q, reg_write_d, reg_write_q, illegal_d, illegal_q;
    logic [1:0]  alu_op_d, alu_op_q;
    logic [3:0]  reg1_d, reg1_q, reg2_d, reg2_q, reg_dest_d, reg_dest_q;
    logic [15:0] imm_d, imm_q;
    always_comb begin
        op          = instruction[31:28];
        is_imm_op   = (op == 4'h3) || (op == 4'h5);
        legal_reg   = (op == 4'h1) || (op == 4'h2) || (op == 4'h4) || (op == 4'h6) || (op == 4'h7);
        legal_imm   = IMM_EN && is_imm_op;
        illegal_d   = op[3] || (!IMM_EN && is_imm_op);
        alu_op_d    = !(legal_reg || legal_imm) ? 2'b00 :
                      (op == 4'h6) ? 2'b10 :
                      (op == 4'h7) ? 2'b11 :
                      (op == 4'h1 || op == 4'h4 || op == 4'h5) ? 2'b01 : 2'b00;
        alu_src_d   = legal_imm;
        reg_write_d = (legal_reg && op != 4'h1) || legal_imm;
        reg1_d      = (legal_reg || legal_imm) ? instruction[23:20] : 4'h0;
        reg2_d      = legal_reg ? instruction[19:16] : 4'h0;
        reg_dest_d  = reg_write_d ? instruction[27:24] : 4'h0;
        imm_d       = legal_imm ? instruction[15:0] : 16'h0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_src_q   <= 1'b0;
            alu_op_q    <= 2'b00;
            reg1_q      <= 4'h0;
            reg2_q      <= 4'h0;
            reg_dest_q  <= 4'h0;
            imm_q       <= 16'h0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            alu_src_q   <= alu_src_d;
            alu_op_q    <= alu_op_d;
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            reg_dest_q  <= reg_dest_d;
            imm_q       <= imm_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
        end
    end
    assign alu_src   = alu_src_q;
    assign alu_op    = alu_op_q;
    assign reg1      = reg1_q;
    assign reg2      = reg2_q;
    assign reg_dest  = reg_dest_q;
    assign imm       = imm_q;
    assign reg_write = reg_write_q;
    assign illegal   = illegal_q;
endmodule

// File: tb/tb_instruction_decoder.sv
// tb_instruction_decoder: random and directed checks of instruction_decoder against an opcode-table model.
module tb_instruction_decoder;
`ifdef DEC_IMM_EN
    localparam bit IMM_EN = 1'b1;
`else
    localparam bit IMM_EN = 1'b0;
`endif
    localparam logic [1:0] AOP [8] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic        alu_src, reg_write, illegal;
    logic [1:0]  alu_op;
    logic [3:0]  reg1, reg2, reg_dest;
    logic [15:0] imm;
    int n_chk = 0;
    int n_pass = 0;
    instruction_decoder dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .alu_src(alu_src), .alu_op(alu_op), .reg1(reg1), .reg2(reg2),
        .reg_dest(reg_dest), .imm(imm), .reg_write(reg_write), .illegal(illegal)
    );
    always #5 clk = ~clk;
    function automatic logic [32:0] observed();
        return {illegal, reg_write, alu_src, alu_op, reg_dest, reg1, reg2, imm};
    endfunction
    // Expected output vector, same packing as observed().
    function automatic logic [32:0] model(input logic [31:0] x);
        int  op = int'(x[31:28]);
        bit  imm_form = (op == 3) || (op == 5);
        bit  wr;
        if (op >= 8 || (imm_form && !IMM_EN)) return {1'b1, 32'h0};
        if (op == 0) return 33'h0;
        wr = (op >= 2);
        return {1'b0, wr, imm_form, AOP[op], wr ? x[27:24] : 4'h0, x[23:20],
                imm_form ? 4'h0 : x[19:16], imm_form ? x[15:0] : 16'h0};
    endfunction
    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic apply(input string tag, input logic [31:0] x);
        @(negedge clk) instruction = x;
        @(posedge clk) #1 check(tag, observed(), model(x));
    endtask
    initial begin
        logic [31:0] r;
        #1 rst = 1'b1;
        #1 check("reset_async", observed(), 33'h0);
        instruction = 32'h21350001;
        @(posedge clk) #1 check("reset_hold", observed(), 33'h0);
        @(negedge clk) begin rst = 1'b0; instruction = 32'h0; end
        @(posedge clk) #1 check("first_nop", observed(), 33'h0);
        apply("add", 32'h21350001);
        check("add_lit", observed(), {1'b0, 1'b1, 1'b0, 2'b00, 4'h1, 4'h3, 4'h5, 16'h0});
        apply("sub", 32'h47410001);
        check("sub_lit", observed(), {1'b0, 1'b1, 1'b0, 2'b01, 4'h7, 4'h4, 4'h1, 16'h0});
        apply("addi", 32'h3A90BEEF);
        check("addi_lit", observed(), IMM_EN ? {1'b0, 1'b1, 1'b1, 2'b00, 4'hA, 4'h9, 4'h0, 16'hBEEF}
                                             : {1'b1, 32'h0});
        apply("subi", 32'h5C3D1234);
        apply("illegal", 32'h9FFFFFFF);
        check("illegal_lit", observed(), {1'b1, 32'h0});
        apply("cmp", 32'h1123ABCD);
        check("cmp_lit", observed(), {1'b0, 1'b0, 1'b0, 2'b01, 4'h0, 4'h2, 4'h3, 16'h0});
        apply("nop_fields", 32'h0FFFFFFF);
        apply("and", 32'h6ABC0000);
        apply("orr", 32'h7DEF5555);
        apply("op_f", 32'hF1234567);
        apply("hold_add", 32'h21350001);
        @(negedge clk) instruction = 32'h9FFFFFFF;
        #1 check("hold_between_edges", observed(), model(32'h21350001));
        @(posedge clk) #1 check("after_change", observed(), model(32'h9FFFFFFF));
        apply("pre_rst_add", 32'h2F350001);
        @(negedge clk) #2 rst = 1'b1;
        #1 check("midstream_rst", observed(), 33'h0);
        rst = 1'b0;
        @(posedge clk) #1 check("post_rst", observed(), model(instruction));
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            apply("random", r);
        end
        for (int i = 0; i < 16; i++) begin
            r = $urandom;
            r[31:28] = 4'(i);
            apply("sweep", r);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
